// File: rtl/inst_fetch_unit_if.sv
// IF/ID boundary bundle: fetched word, its PC, fault flags and the valid/ready handshake.
// The fetch unit is the master; decode is the slave.
interface inst_fetch_unit_if;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic        inst_misalign_o;
  logic        inst_oob_o;

  modport master (
    output inst_o, inst_pc_o, inst_valid_o, inst_misalign_o, inst_oob_o,
    input  inst_ready_i
  );

  modport slave (
    input  inst_o, inst_pc_o, inst_valid_o, inst_misalign_o, inst_oob_o,
    output inst_ready_i
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Fetch stage for a 1-cycle synchronous-read instruction BRAM: issues word addresses,
// tags returned words with their PC, handles backpressure/redirects and flags faulting fetches.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 14,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_en_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  output logic [29:0]            iram_addr_o,
  input  logic [31:0]            iram_rdata_i,
  inst_fetch_unit_if.master      id_if,
  output logic [31:0]            fetch_cnt_o,
  output logic [31:0]            stall_cnt_o
);

  logic [31:0] pc_q, pc_d;
  logic        f1_valid_q, f1_valid_d;
  logic [31:0] f1_pc_q, f1_pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic hold;
  logic fire;
  logic valid_out;
  logic misalign;
  logic oob;

  assign hold      = f1_valid_q & ~id_if.inst_ready_i & ~redirect_i;
  assign valid_out = f1_valid_q & ~redirect_i;
  assign fire      = valid_out & id_if.inst_ready_i;
  assign misalign  = |f1_pc_q[1:0];
  assign oob       = |f1_pc_q[31:IMEM_AW];

  // Address mux feeds the BRAM's own input register, so the ready/redirect path stays combinational.
  always_comb begin
    iram_addr_o = pc_q[31:2];
    if (redirect_i) begin
      iram_addr_o = redirect_pc_i[31:2];
    end else if (hold) begin
      iram_addr_o = f1_pc_q[31:2];
    end
  end

  always_comb begin
    pc_d        = pc_q;
    f1_valid_d  = f1_valid_q;
    f1_pc_d     = f1_pc_q;
    fetch_cnt_d = fetch_cnt_q + (fire ? 32'd1 : 32'd0);
    stall_cnt_d = stall_cnt_q + ((valid_out & ~id_if.inst_ready_i) ? 32'd1 : 32'd0);
    if (redirect_i) begin
      f1_valid_d = fetch_en_i;
      f1_pc_d    = redirect_pc_i;
      pc_d       = redirect_pc_i + 32'd4;
    end else if (hold) begin
      // BRAM re-reads f1_pc, so the held word stays stable without a local copy.
      f1_valid_d = f1_valid_q;
    end else if (fetch_en_i) begin
      f1_valid_d = 1'b1;
      f1_pc_d    = pc_q;
      pc_d       = pc_q + 32'd4;
    end else begin
      f1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      f1_valid_q  <= 1'b0;
      f1_pc_q     <= RESET_PC;
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      f1_valid_q  <= f1_valid_d;
      f1_pc_q     <= f1_pc_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    id_if.inst_valid_o    = valid_out;
    id_if.inst_pc_o       = f1_pc_q;
    id_if.inst_misalign_o = valid_out & misalign;
    id_if.inst_oob_o      = valid_out & oob;
    if (!f1_valid_q) begin
      id_if.inst_o = 32'd0;
    end else if (misalign | oob) begin
      id_if.inst_o = NOP_INST;
    end else begin
      id_if.inst_o = iram_rdata_i;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a transaction-level model of the fetch stream is
// compared with the DUT every cycle, plus hand-computed literal checks at key points.
module tb_inst_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          IMEM_AW  = 14;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [29:0] iram_addr;
  logic [31:0] iram_rdata;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  inst_fetch_unit_if ifc();

  inst_fetch_unit #(
    .RESET_PC(RESET_PC), .IMEM_AW(IMEM_AW), .NOP_INST(NOP_INST)
  ) dut (
    .clk(clk), .rst(rst), .fetch_en_i(fetch_en), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .iram_addr_o(iram_addr), .iram_rdata_i(iram_rdata),
    .id_if(ifc.master), .fetch_cnt_o(fetch_cnt), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: word at word-address a is A000_0000 + a.
  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return 32'hA000_0000 + {2'b00, a};
  endfunction

  // BRAM: one-cycle synchronous read.
  always @(posedge clk) iram_rdata <= mem_word(iram_addr);

  // Model: what the decode side should be seeing, as a stream of PCs.
  bit          m_init  = 0;
  bit          m_show  = 0;
  logic [31:0] m_pc    = 32'd0;
  logic [31:0] m_next  = 32'd0;
  logic [31:0] m_fetch = 32'd0;
  logic [31:0] m_stall = 32'd0;

  always @(posedge clk) begin
    if (rst) begin
      m_init  = 1;
      m_show  = 0;
      m_next  = RESET_PC;
      m_fetch = 0;
      m_stall = 0;
    end else if (m_init) begin
      if (m_show && !redirect && ifc.inst_ready_i)  m_fetch = m_fetch + 1;
      if (m_show && !redirect && !ifc.inst_ready_i) m_stall = m_stall + 1;
      if (redirect) begin
        m_show = fetch_en;
        m_pc   = redirect_pc;
        m_next = redirect_pc + 32'd4;
      end else if (m_show && !ifc.inst_ready_i) begin
        m_show = 1;  // word not taken: same word stays on offer
      end else if (fetch_en) begin
        m_show = 1;
        m_pc   = m_next;
        m_next = m_next + 32'd4;
      end else begin
        m_show = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_init && !rst) begin
      logic        e_valid;
      logic        fault;
      logic [29:0] e_addr;
      e_valid = m_show && !redirect;
      fault   = (m_pc[1:0] != 2'b00) || ((m_pc >> IMEM_AW) != 32'd0);
      if (redirect)                           e_addr = redirect_pc[31:2];
      else if (m_show && !ifc.inst_ready_i)   e_addr = m_pc[31:2];
      else                                    e_addr = m_next[31:2];
      check("valid", {31'd0, ifc.inst_valid_o}, {31'd0, e_valid});
      check("addr", {2'b00, iram_addr}, {2'b00, e_addr});
      check("inst", ifc.inst_o, !m_show ? 32'd0 : fault ? NOP_INST : mem_word(m_pc[31:2]));
      if (m_show) check("pc", ifc.inst_pc_o, m_pc);
      check("misalign", {31'd0, ifc.inst_misalign_o}, {31'd0, e_valid && (m_pc[1:0] != 2'b00)});
      check("oob", {31'd0, ifc.inst_oob_o}, {31'd0, e_valid && ((m_pc >> IMEM_AW) != 32'd0)});
      check("fetch_cnt", fetch_cnt, m_fetch);
      check("stall_cnt", stall_cnt, m_stall);
    end
  end

  task automatic drive(input bit r, input bit en, input bit rdy, input bit rd, input logic [31:0] rpc);
    rst = r; fetch_en = en; ifc.inst_ready_i = rdy; redirect = rd; redirect_pc = rpc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic show(input string tag);
    $display("[TB] %s: valid=%0b pc=%08h inst=%08h mis=%0b oob=%0b fetch=%0d stall=%0d",
             tag, ifc.inst_valid_o, ifc.inst_pc_o, ifc.inst_o, ifc.inst_misalign_o,
             ifc.inst_oob_o, fetch_cnt, stall_cnt);
  endtask

  initial begin
    drive(1, 0, 1, 0, 32'd0);
    tick(); tick();
    // T1: reset state, then back-to-back stream
    drive(0, 1, 1, 0, 32'd0);
    check("T1 reset valid", {31'd0, ifc.inst_valid_o}, 32'd0);
    check("T1 reset fetch", fetch_cnt, 32'd0);
    tick(); show("T1 w0");
    check("T1 pc0", ifc.inst_pc_o, 32'h0);
    check("T1 inst0", ifc.inst_o, 32'hA000_0000);
    tick(); show("T1 w1");
    check("T1 pc1", ifc.inst_pc_o, 32'h4);
    tick(); show("T1 w2");
    check("T1 inst2", ifc.inst_o, 32'hA000_0002);
    check("T1 fetch2", fetch_cnt, 32'd2);
    // T2: three stall cycles while pc 8 showing
    drive(0, 1, 0, 0, 32'd0);
    tick(); tick(); tick(); show("T2 hold");
    check("T2 pc hold", ifc.inst_pc_o, 32'h8);
    check("T2 inst hold", ifc.inst_o, 32'hA000_0002);
    check("T2 stall3", stall_cnt, 32'd3);
    drive(0, 1, 1, 0, 32'd0);
    tick(); show("T2 next");
    check("T2 pc12", ifc.inst_pc_o, 32'hC);
    tick(); show("T2 next2");
    // T3: redirect to 4, then redirect to 0x40 while 4 is held
    drive(0, 1, 1, 1, 32'h4);
    tick(); show("T3 at4");
    drive(0, 1, 0, 1, 32'h40);
    check("T3 killed valid", {31'd0, ifc.inst_valid_o}, 32'd0);
    tick(); show("T3 at40");
    check("T3 pc40", ifc.inst_pc_o, 32'h40);
    drive(0, 1, 1, 0, 32'd0);
    tick(); show("T3 at44");
    check("T3 pc44", ifc.inst_pc_o, 32'h44);
    // T4: misaligned and out-of-range targets
    drive(0, 1, 1, 1, 32'h42);
    tick(); show("T4 mis");
    drive(0, 1, 1, 0, 32'd0);
    check("T4 misalign", {31'd0, ifc.inst_misalign_o}, 32'd1);
    check("T4 nop", ifc.inst_o, 32'h0000_0013);
    tick(); show("T4 mis2");
    drive(0, 1, 1, 1, 32'h4000);
    tick(); show("T4 oob");
    drive(0, 1, 1, 0, 32'd0);
    check("T4 oob", {31'd0, ifc.inst_oob_o}, 32'd1);
    check("T4 oob nop", ifc.inst_o, 32'h0000_0013);
    // T5: fetch disabled for two cycles
    drive(0, 0, 1, 0, 32'd0);
    tick(); show("T5 off1");
    check("T5 valid off", {31'd0, ifc.inst_valid_o}, 32'd0);
    tick(); show("T5 off2");
    drive(0, 1, 1, 0, 32'd0);
    tick(); show("T5 resume");
    check("T5 pc resume", ifc.inst_pc_o, 32'h4004);
    // PC wrap at 2^32
    drive(0, 1, 1, 1, 32'hFFFF_FFFC);
    tick(); show("wrap hi");
    drive(0, 1, 1, 0, 32'd0);
    tick(); show("wrap lo");
    check("wrap pc0", ifc.inst_pc_o, 32'h0);
    check("wrap inst", ifc.inst_o, 32'hA000_0000);
    // T6: reset during hold with a concurrent redirect
    drive(0, 1, 0, 0, 32'd0);
    tick(); show("T6 hold");
    drive(1, 1, 0, 1, 32'h80);
    tick();
    drive(0, 1, 1, 0, 32'd0);
    show("T6 reset");
    check("T6 valid", {31'd0, ifc.inst_valid_o}, 32'd0);
    check("T6 fetch0", fetch_cnt, 32'd0);
    check("T6 stall0", stall_cnt, 32'd0);
    tick(); show("T6 restart");
    check("T6 pc restart", ifc.inst_pc_o, RESET_PC);
    tick(); tick();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
